ac_motor_pwm_deadtime: RTL and testbench

//  Consumer end of the AC_MOTOR_TRIANGLE carrier interface. Compares a signed duty reference against
//  the triangle carrier and drives the four gates of one H-bridge (legs A/B), honouring cw/ccw

---
 rtl/ac_motor_pwm_deadtime_if.sv | 27 ++
 rtl/ac_motor_pwm_deadtime.sv | 145 ++++++++++++++
 tb/tb_ac_motor_pwm_deadtime.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/ac_motor_pwm_deadtime_if.sv
// Carrier/duty/direction inputs and gate outputs of one H-bridge PWM stage.
// The master side drives the carrier, reference and direction. The slave side drives the gates.
interface ac_motor_pwm_deadtime_if #(
  parameter int WIDTH = 24
);
  logic signed [WIDTH-1:0] triangle;
  logic signed [WIDTH-1:0] duty;
  logic                    cw_in;
  logic                    ccw_in;
  logic                    lock;
  logic                    a_hi;
  logic                    a_lo;
  logic                    b_hi;
  logic                    b_lo;
  logic                    active;
  logic                    fault;

  modport master (
    output triangle, duty, cw_in, ccw_in, lock,
    input  a_hi, a_lo, b_hi, b_lo, active, fault
  );

  modport slave (
    input  triangle, duty, cw_in, ccw_in, lock,
    output a_hi, a_lo, b_hi, b_lo, active, fault
  );
endinterface

// File: rtl/ac_motor_pwm_deadtime.sv
// Triangle-compare PWM for one H-bridge. Each leg has its own FSM that inserts
// DEAD_CYCLES of both-off time on every high/low swap.
module ac_motor_pwm_deadtime #(
  parameter int WIDTH       = 24,
  parameter int DEAD_CYCLES = 50,
  parameter int CNT_W       = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  ac_motor_pwm_deadtime_if.slave bus
);
  typedef enum logic [1:0] {S_OFF, S_DT, S_HI, S_LO} state_t;

  localparam logic [CNT_W-1:0] DEAD_LOAD =
      (DEAD_CYCLES < 1) ? CNT_W'(1) : CNT_W'(DEAD_CYCLES);
  localparam logic signed [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic signed [WIDTH-1:0] MOST_POS = {1'b0, {(WIDTH-1){1'b1}}};

  function automatic logic signed [WIDTH-1:0] sat_neg(input logic signed [WIDTH-1:0] v);
    if (v == MOST_NEG) return MOST_POS;
    return -v;
  endfunction

  logic signed [WIDTH-1:0] triangle_q, duty_q;
  logic                    cw_q, ccw_q, lock_q;
  logic                    fault_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      triangle_q <= '0;
      duty_q     <= '0;
      cw_q       <= 1'b0;
      ccw_q      <= 1'b0;
      lock_q     <= 1'b0;
      fault_reg  <= 1'b0;
    end else begin
      triangle_q <= bus.triangle;
      duty_q     <= bus.duty;
      cw_q       <= bus.cw_in;
      ccw_q      <= bus.ccw_in;
      lock_q     <= bus.lock;
      fault_reg  <= cw_q & ccw_q;
    end
  end

  logic                    enable;
  logic signed [WIDTH-1:0] ref_val, ref_neg;
  logic signed [WIDTH:0]   ref_x, ref_neg_x, tri_x;
  logic [1:0]              dem;

  // Saturated references are sign-extended one bit so the compare itself cannot wrap.
  always_comb begin
    enable    = !lock_q & (cw_q ^ ccw_q);
    ref_val   = cw_q ? duty_q : sat_neg(duty_q);
    ref_neg   = sat_neg(ref_val);
    ref_x     = {ref_val[WIDTH-1], ref_val};
    ref_neg_x = {ref_neg[WIDTH-1], ref_neg};
    tri_x     = {triangle_q[WIDTH-1], triangle_q};
    dem[0]    = ref_x > tri_x;
    dem[1]    = ref_neg_x > tri_x;
  end

  logic [1:0] hi_next, lo_next, on_next;

  for (genvar gi = 0; gi < 2; gi++) begin : g_leg
    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             tgt_reg, tgt_next;

    always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      tgt_next   = tgt_reg;
      if (!enable) begin
        state_next = S_OFF;
        cnt_next   = '0;
      end else begin
        case (state_reg)
          S_OFF: begin
            state_next = S_DT;
            tgt_next   = dem[gi];
            cnt_next   = DEAD_LOAD;
          end
          // The count keeps running if the demand flips mid-dead-time; the new target is simply taken at the end.
          S_DT: begin
            tgt_next = dem[gi];
            cnt_next = cnt_reg - CNT_W'(1);
            if (cnt_reg == CNT_W'(1)) begin
              state_next = tgt_next ? S_HI : S_LO;
              cnt_next   = '0;
            end
          end
          S_HI: if (!dem[gi]) begin
            state_next = S_DT;
            cnt_next   = DEAD_LOAD;
          end
          S_LO: if (dem[gi]) begin
            state_next = S_DT;
            cnt_next   = DEAD_LOAD;
          end
          default: state_next = S_OFF;
        endcase
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state_reg <= S_OFF;
        cnt_reg   <= '0;
        tgt_reg   <= 1'b0;
      end else begin
        state_reg <= state_next;
        cnt_reg   <= cnt_next;
        tgt_reg   <= tgt_next;
      end
    end

    assign hi_next[gi] = (state_next == S_HI);
    assign lo_next[gi] = (state_next == S_LO);
    assign on_next[gi] = (state_next != S_OFF);
  end

  logic [1:0] hi_reg, lo_reg;
  logic       active_reg;

  // Gates are decoded from the next state, so they line up with the state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_reg     <= '0;
      lo_reg     <= '0;
      active_reg <= 1'b0;
    end else begin
      hi_reg     <= hi_next;
      lo_reg     <= lo_next;
      active_reg <= |on_next;
    end
  end

  assign bus.a_hi   = hi_reg[0];
  assign bus.a_lo   = lo_reg[0];
  assign bus.b_hi   = hi_reg[1];
  assign bus.b_lo   = lo_reg[1];
  assign bus.active = active_reg;
  assign bus.fault  = fault_reg;
endmodule

// File: tb/tb_ac_motor_pwm_deadtime.sv
// Directed bench for ac_motor_pwm_deadtime with a dead time of 4 cycles.
// Gate vector order is {a_hi, a_lo, b_hi, b_lo, active, fault}.
module tb_ac_motor_pwm_deadtime;
  localparam int WIDTH = 24;

  logic clk;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic mon_en   = 1'b0;

  ac_motor_pwm_deadtime_if #(.WIDTH(WIDTH)) bus ();

  ac_motor_pwm_deadtime #(.WIDTH(WIDTH), .DEAD_CYCLES(4), .CNT_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  task automatic check_gates(input string tag, input logic [5:0] exp);
    check_eq(tag, {26'd0, bus.a_hi, bus.a_lo, bus.b_hi, bus.b_lo, bus.active, bus.fault},
             {26'd0, exp});
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic cw, input logic ccw, input logic lk,
                       input logic [WIDTH-1:0] d, input logic [WIDTH-1:0] t);
    bus.cw_in    = cw;
    bus.ccw_in   = ccw;
    bus.lock     = lk;
    bus.duty     = d;
    bus.triangle = t;
  endtask

  // Shoot-through check on every falling edge.
  always @(negedge clk) begin
    if (mon_en)
      check_eq("no_overlap", {30'd0, bus.a_hi & bus.a_lo, bus.b_hi & bus.b_lo}, 32'd0);
  end

  initial begin
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 24'h000000, 24'h000000);
    #1;
    check_gates("reset_async", 6'b000000);
    step(2);
    check_gates("reset_held", 6'b000000);
    reset  = 1'b0;
    mon_en = 1'b1;

    // 1: clockwise, duty 0x100000, triangle at 0 / above / below
    drive(1'b1, 1'b0, 1'b0, 24'h100000, 24'h000000);
    step(2); check_gates("t1_enter_dt", 6'b000010);
    step(3); check_gates("t1_dt_hold", 6'b000010);
    step(1); check_gates("t1_a_hi_b_lo", 6'b100110);
    drive(1'b1, 1'b0, 1'b0, 24'h100000, 24'h200000);
    step(2); check_gates("t1_a_hi_fall", 6'b000110);
    step(3); check_gates("t1_a_gap", 6'b000110);
    step(1); check_gates("t1_a_lo_rise", 6'b010110);
    drive(1'b1, 1'b0, 1'b0, 24'h100000, 24'hE00000);
    step(2); check_gates("t1_both_dt", 6'b000010);
    step(3); check_gates("t1_both_gap", 6'b000010);
    step(1); check_gates("t1_both_hi", 6'b101010);

    // 2: direction reversal to ccw, triangle 0
    drive(1'b0, 1'b1, 1'b0, 24'h100000, 24'h000000);
    step(2); check_gates("t2_a_fall", 6'b001010);
    step(3); check_gates("t2_a_gap", 6'b001010);
    step(1); check_gates("t2_swapped", 6'b011010);

    // 3: lock while a_hi
    drive(1'b1, 1'b0, 1'b0, 24'h100000, 24'h000000);
    step(6); check_gates("t3_pre_lock", 6'b100110);
    drive(1'b1, 1'b0, 1'b1, 24'h100000, 24'h000000);
    step(1); check_gates("t3_lock_1edge", 6'b100110);
    step(1); check_gates("t3_lock_off", 6'b000000);
    step(3); check_gates("t3_lock_hold", 6'b000000);
    drive(1'b1, 1'b0, 1'b0, 24'h100000, 24'h000000);
    step(2); check_gates("t3_unlock_dt", 6'b000010);
    step(3); check_gates("t3_unlock_gap", 6'b000010);
    step(1); check_gates("t3_resume", 6'b100110);

    // 4: cw and ccw together
    drive(1'b1, 1'b1, 1'b0, 24'h100000, 24'h000000);
    step(1); check_gates("t4_fault_1edge", 6'b100110);
    step(1); check_gates("t4_fault_on", 6'b000001);
    drive(1'b1, 1'b0, 1'b0, 24'h100000, 24'h000000);
    step(1); check_gates("t4_fault_linger", 6'b000001);
    step(1); check_gates("t4_fault_clear", 6'b000010);
    step(3); check_gates("t4_restart_gap", 6'b000010);
    step(1); check_gates("t4_restart", 6'b100110);

    // 5: most-negative duty under ccw saturates
    drive(1'b1, 1'b0, 1'b1, 24'h100000, 24'h000000);
    step(3); check_gates("t5_locked", 6'b000000);
    drive(1'b0, 1'b1, 1'b0, 24'h800000, 24'h7FFFFE);
    step(2); check_gates("t5_dt", 6'b000010);
    step(3); check_gates("t5_gap", 6'b000010);
    step(1); check_gates("t5_a_hi", 6'b100110);
    drive(1'b0, 1'b1, 1'b0, 24'h800000, 24'h800000);
    step(2); check_gates("t5_tri_min_a", 6'b100010);
    step(4); check_gates("t5_tri_min_b", 6'b101010);
    drive(1'b0, 1'b1, 1'b0, 24'h800000, 24'h7FFFFF);
    step(2); check_gates("t5_tri_max_dt", 6'b000010);
    step(4); check_gates("t5_tri_max_lo", 6'b010110);

    // 6: asynchronous reset mid-PWM
    drive(1'b1, 1'b0, 1'b0, 24'h100000, 24'h000000);
    step(2); check_gates("t6_a_dt", 6'b000110);
    step(4); check_gates("t6_a_hi", 6'b100110);
    drive(1'b1, 1'b0, 1'b0, 24'h100000, 24'hE00000);
    step(3); check_gates("t6_b_busy", 6'b100010);
    #2 reset = 1'b1;
    #1 check_gates("t6_reset_async", 6'b000000);
    step(2); check_gates("t6_reset_held", 6'b000000);
    reset = 1'b0;
    step(2); check_gates("t6_release_dt", 6'b000010);
    step(3); check_gates("t6_release_gap", 6'b000010);
    step(1); check_gates("t6_release_on", 6'b101010);

    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
